sprite_line_renderer: RTL and testbench

Per-scanline sprite fetch and pixel-colour stage that sits directly downstream of a 16-entry sprite palette (e.g. the player-1 shield palette).

- During horizontal blanking it fetches one sprite row of 4-bit colour indices from sprite ROM into an internal line buffer.
- During active video it maps the current pixel to a buffered index, resolves it through the palette's `color_map`, and emits 24-bit RGB plus an opaque flag.
- Its output feeds the layer compositor.

---
 rtl/sprite_line_renderer.sv | 189 ++++++++++++++++++
 tb/tb_sprite_line_renderer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer: fetches one sprite row of palette indices from ROM
// into a line buffer during hblank, then during active video turns each pixel
// into a buffered index and resolves it through the palette.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no fetch running; line_valid_q says whether linebuf holds a row
// FETCH | one ROM request per cycle, col 0 .. SPR_W-1
// DRAIN | last ROM word lands in linebuf; line_valid_q is set on exit
module sprite_line_renderer #(
  parameter int SPR_W  = 64,
  parameter int SPR_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_line_start,
  input  logic [9:0]        i_next_y,
  input  logic              i_spr_en,
  input  logic [9:0]        i_spr_x,
  input  logic [9:0]        i_spr_y,
  input  logic              i_de,
  input  logic [9:0]        i_h_cnt,
  output logic              o_rom_req,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [3:0]        i_rom_data,
  input  logic [23:0]       i_color_map [0:15],
  output logic [23:0]       o_rgb,
  output logic              o_opaque,
  output logic              o_busy
);

  localparam int CW = $clog2(SPR_W);
  // Because SPR_W is a power of two, row*SPR_W + col is just {row, col}.
  localparam int RW = ADDR_W - CW;
  localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t              state_q;
  logic [RW-1:0]       row_q;
  logic [CW-1:0]       col_q;
  logic                line_valid_q;
  logic                rom_req_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic                busy_q;

  logic                req_dly_q;
  logic [CW-1:0]       col_dly_q;
  logic [3:0]          linebuf [0:SPR_W-1];

  logic                in_q;
  logic [3:0]          idx_q;
  logic [23:0]         rgb_q;
  logic                opaque_q;

  logic [10:0]         row_d;
  logic                hit_d;
  logic [CW-1:0]       col_inc_d;
  logic [10:0]         px_d;
  logic                in_d;
  logic [3:0]          idx_d;
  logic                wr_en_d;

  // Row of the upcoming line relative to the sprite top, and whether it is drawn
  always_comb begin
    row_d     = {1'b0, i_next_y} - {1'b0, i_spr_y};
    hit_d     = i_spr_en & ~row_d[10] & (row_d < 11'(SPR_H));
    col_inc_d = col_q + 1'b1;
  end

  // Fetch sequencer; a line_start in any state restarts from the new sample
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      line_valid_q <= 1'b0;
      rom_req_q    <= 1'b0;
      rom_addr_q   <= '0;
      busy_q       <= 1'b0;
    end else if (i_line_start) begin
      line_valid_q <= 1'b0;
      row_q        <= row_d[RW-1:0];
      col_q        <= '0;
      if (hit_d) begin
        state_q    <= FETCH;
        rom_req_q  <= 1'b1;
        rom_addr_q <= {row_d[RW-1:0], {CW{1'b0}}};
        busy_q     <= 1'b1;
      end else begin
        state_q    <= IDLE;
        rom_req_q  <= 1'b0;
        rom_addr_q <= '0;
        busy_q     <= 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          rom_req_q  <= 1'b0;
          rom_addr_q <= '0;
          busy_q     <= 1'b0;
        end
        FETCH: begin
          if (col_q == COL_LAST) begin
            state_q    <= DRAIN;
            rom_req_q  <= 1'b0;
            rom_addr_q <= '0;
          end else begin
            col_q      <= col_inc_d;
            rom_req_q  <= 1'b1;
            rom_addr_q <= {row_q, col_inc_d};
          end
        end
        DRAIN: begin
          state_q      <= IDLE;
          line_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          col_q        <= '0;
        end
        default: begin
          state_q    <= IDLE;
          rom_req_q  <= 1'b0;
          rom_addr_q <= '0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // ROM answers one cycle after the request, so delay req and col to match
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_dly_q <= 1'b0;
      col_dly_q <= '0;
    end else begin
      req_dly_q <= rom_req_q;
      col_dly_q <= col_q;
    end
  end

  // A stale write right after an abort is harmless: the new fetch rewrites every column
  always_comb begin
    wr_en_d = req_dly_q & ((state_q == FETCH) | (state_q == DRAIN));
  end

  // Line buffer write; contents are don't-care until line_valid_q is set
  always_ff @(posedge i_clk) begin
    if (wr_en_d) begin
      linebuf[col_dly_q] <= i_rom_data;
    end
  end

  // Pixel position inside the sprite and the buffered index under it
  always_comb begin
    px_d  = {1'b0, i_h_cnt} - {1'b0, i_spr_x};
    in_d  = i_de & line_valid_q & ~px_d[10] & (px_d < 11'(SPR_W));
    idx_d = in_d ? linebuf[px_d[CW-1:0]] : 4'd0;
  end

  // Pixel stage 1: capture index and coverage
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      in_q  <= 1'b0;
      idx_q <= 4'd0;
    end else begin
      in_q  <= in_d;
      idx_q <= idx_d;
    end
  end

  // Pixel stage 2: palette lookup; index 0 is transparent
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      opaque_q <= 1'b0;
      rgb_q    <= 24'h000000;
    end else begin
      opaque_q <= in_q & (idx_q != 4'd0);
      rgb_q    <= (in_q && (idx_q != 4'd0)) ? i_color_map[idx_q] : 24'h000000;
    end
  end

  assign o_rom_req  = rom_req_q;
  assign o_rom_addr = rom_addr_q;
  assign o_busy     = busy_q;
  assign o_rgb      = rgb_q;
  assign o_opaque   = opaque_q;

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Directed bench for sprite_line_renderer. ROM returns col[3:0] for every row,
// so buffered index at sprite pixel px is px mod 16.
module tb_sprite_line_renderer;

  localparam int SPR_W = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_start = 1'b0;
  logic [9:0]  next_y = '0;
  logic        spr_en = 1'b0;
  logic [9:0]  spr_x = '0;
  logic [9:0]  spr_y = '0;
  logic        de = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic        rom_req;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data = 4'd0;
  logic [23:0] cmap [0:15];
  logic [23:0] rgb;
  logic        opaque;
  logic        busy;

  int   n_cmp = 0;
  int   n_err = 0;
  logic lv_exp = 1'b0;

  sprite_line_renderer #(.SPR_W(64), .SPR_H(64), .ADDR_W(12)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_line_start (line_start),
    .i_next_y     (next_y),
    .i_spr_en     (spr_en),
    .i_spr_x      (spr_x),
    .i_spr_y      (spr_y),
    .i_de         (de),
    .i_h_cnt      (h_cnt),
    .o_rom_req    (rom_req),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .i_color_map  (cmap),
    .o_rgb        (rgb),
    .o_opaque     (opaque),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // ROM model: index = column low nibble, one cycle latency
  always @(posedge clk) rom_data <= rom_addr[3:0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] exp_px(input int x, input int sx, input logic lv);
    int px;
    px = x - sx;
    if (lv && px >= 0 && px < SPR_W && (px % 16) != 0)
      return {1'b1, cmap[px % 16]};
    return 25'd0;
  endfunction

  // Drive h_cnt = start .. start+cnt-1 back to back and check each result two cycles on
  task automatic stream(input int start, input int cnt, input string tag);
    logic [24:0] e;
    de = 1'b1;
    for (int c = 0; c <= cnt; c++) begin
      if (c < cnt) h_cnt = 10'(start + c);
      tick();
      if (c >= 1) begin
        e = exp_px(start + c - 1, int'(spr_x), lv_exp);
        expect_eq($sformatf("%s_op@%0d", tag, start + c - 1), {31'd0, opaque}, {31'd0, e[24]});
        expect_eq($sformatf("%s_rgb@%0d", tag, start + c - 1), {8'd0, rgb}, {8'd0, e[23:0]});
      end
    end
  endtask

  // Watch 70 cycles of fetch activity starting at the cycle after line_start
  task automatic monitor(input int exp_reqs, input int base, input string tag);
    int nreq, nbusy, nbad;
    nreq = 0; nbusy = 0; nbad = 0;
    for (int k = 0; k < 70; k++) begin
      if (rom_req === 1'b1) begin
        if (rom_addr !== 12'(base + nreq)) nbad++;
        nreq++;
      end
      if (busy === 1'b1) nbusy++;
      tick();
    end
    expect_eq({tag, "_reqs"}, 32'(nreq), 32'(exp_reqs));
    expect_eq({tag, "_busy"}, 32'(nbusy), (exp_reqs != 0) ? 32'(exp_reqs + 1) : 32'd0);
    expect_eq({tag, "_badaddr"}, 32'(nbad), 32'd0);
  endtask

  task automatic do_line(input int ny, input logic en, input int exp_reqs, input int base, input string tag);
    next_y = 10'(ny);
    spr_en = en;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    lv_exp = 1'b0;
    monitor(exp_reqs, base, tag);
    lv_exp = (exp_reqs != 0);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) cmap[k] = 24'h010203 * 24'(k) + 24'h100000;
    cmap[5] = 24'hc8afa8;

    // Reset held with active video
    rst = 1'b1; de = 1'b1; spr_x = 10'd200; h_cnt = 10'd205;
    repeat (3) tick();
    expect_eq("rst_rgb", {8'd0, rgb}, 32'd0);
    expect_eq("rst_opaque", {31'd0, opaque}, 32'd0);
    expect_eq("rst_req", {31'd0, rom_req}, 32'd0);
    expect_eq("rst_busy", {31'd0, busy}, 32'd0);
    expect_eq("rst_addr", {20'd0, rom_addr}, 32'd0);
    #2 rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      h_cnt = 10'(195 + k);
      tick();
      expect_eq("post_rst_req", {31'd0, rom_req}, 32'd0);
      expect_eq("post_rst_opaque", {31'd0, opaque}, 32'd0);
      expect_eq("post_rst_rgb", {8'd0, rgb}, 32'd0);
    end

    // Row 2 fetch, cycle by cycle
    spr_y = 10'd100; next_y = 10'd102; spr_en = 1'b1;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      expect_eq($sformatf("f_req%0d", k), {31'd0, rom_req}, 32'd1);
      expect_eq($sformatf("f_addr%0d", k), {20'd0, rom_addr}, 32'(128 + k));
      expect_eq($sformatf("f_busy%0d", k), {31'd0, busy}, 32'd1);
      tick();
    end
    expect_eq("drain_req", {31'd0, rom_req}, 32'd0);
    expect_eq("drain_busy", {31'd0, busy}, 32'd1);
    h_cnt = 10'd205;
    tick();
    expect_eq("idle_busy", {31'd0, busy}, 32'd0);
    tick();
    expect_eq("lv_not_yet_op", {31'd0, opaque}, 32'd0);
    tick();
    expect_eq("lv_first_op", {31'd0, opaque}, 32'd1);
    expect_eq("lv_first_rgb", {8'd0, rgb}, 32'h00c8afa8);
    lv_exp = 1'b1;

    stream(195, 75, "x200");
    spr_x = 10'd10;
    stream(5, 75, "x10");
    spr_x = 10'd980;
    stream(975, 48, "x980");
    spr_x = 10'd200;

    // Lines that miss the sprite
    do_line(99, 1'b1, 0, 0, "miss99");
    stream(195, 20, "m99");
    do_line(164, 1'b1, 0, 0, "miss164");
    stream(195, 20, "m164");
    do_line(102, 1'b0, 0, 0, "dis");
    stream(195, 20, "mdis");

    // First and last sprite rows
    do_line(100, 1'b1, 64, 0, "row0");
    stream(195, 20, "r0");
    do_line(163, 1'b1, 64, 4032, "row63");
    stream(255, 12, "r63");

    // Abort at col 30, restart on row 10
    next_y = 10'd102; spr_en = 1'b1;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    lv_exp = 1'b0;
    repeat (30) tick();
    expect_eq("abort_col30", {20'd0, rom_addr}, 32'd158);
    next_y = 10'd110;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    monitor(64, 640, "restart");
    lv_exp = 1'b1;
    stream(195, 20, "rs");

    // Reset mid-fetch
    next_y = 10'd105;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    repeat (10) tick();
    expect_eq("pre_rst_req", {31'd0, rom_req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    expect_eq("async_rst_req", {31'd0, rom_req}, 32'd0);
    expect_eq("async_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    lv_exp = 1'b0;
    monitor(0, 0, "after_rst");
    stream(195, 20, "ar");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
